// File: rtl/cu_fetch_l2_server.sv
`default_nettype none
// ============================================================================
// Module   : cu_fetch_l2_server
// Brief    : Serves compute-unit instruction-fetch bursts from instruction
//            memory through a 2-entry return buffer.
// Revision : 1.0
// ============================================================================
module cu_fetch_l2_server #(
   parameter int MEM_AW = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       fetch_L2cache_info,
   input  logic              fetch_L2cache_req,
   output logic              fetch_L2cache_gnt,
   output logic [31:0]       fetch_L2cache_r_data,
   output logic              fetch_L2cache_r_valid,
   input  logic              fetch_L2cache_r_ready,
   output logic              mem_ren,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              busy,
   output logic              burst_done
);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_ISSUE = 2'd1;
   localparam logic [1:0] c_ST_DRAIN = 2'd2;

   localparam logic [MEM_AW-1:0] c_ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [MEM_AW-1:0] r_addr;
   logic [MEM_AW-1:0] r_last_addr;
   logic [8:0]        r_issue_left;
   logic [8:0]        r_ret_left;
   logic              r_inflight;
   logic [31:0]       r_fifo [0:1];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;

   logic              w_accept;
   logic              w_pop;
   logic              w_push;
   logic [2:0]        w_level;
   logic [8:0]        w_burst_len;

   assign w_burst_len = {1'b0, fetch_L2cache_info[31:24]} + 9'd1;
   assign w_accept    = fetch_L2cache_gnt;
   assign w_pop       = fetch_L2cache_r_valid & fetch_L2cache_r_ready;
   assign w_push      = r_inflight;
   // Buffer occupancy once this cycle's pop and the read already in flight settle.
   assign w_level     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

   assign fetch_L2cache_r_valid = (r_count != 2'd0);
   assign fetch_L2cache_r_data  = r_fifo[r_rd_ptr];
   assign mem_addr              = mem_ren ? r_addr : r_last_addr;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = c_ST_ISSUE;
            end
         end
         c_ST_ISSUE: begin
            if (mem_ren && (r_issue_left == 9'd1)) begin
               w_state_nxt = c_ST_DRAIN;
            end
         end
         c_ST_DRAIN: begin
            if (w_pop && (r_ret_left == 9'd1)) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      fetch_L2cache_gnt = 1'b0;
      mem_ren           = 1'b0;
      busy              = 1'b1;
      burst_done        = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            fetch_L2cache_gnt = fetch_L2cache_req;
            busy              = 1'b0;
         end
         c_ST_ISSUE: begin
            mem_ren = (w_level < 3'd2) && (r_issue_left != 9'd0);
         end
         c_ST_DRAIN: begin
            burst_done = w_pop && (r_ret_left == 9'd1);
         end
         default: busy = 1'b0;
      endcase
   end

   // ------------------------------------------------- address and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr       <= '0;
         r_last_addr  <= '0;
         r_issue_left <= 9'd0;
         r_ret_left   <= 9'd0;
         r_inflight   <= 1'b0;
      end else begin
         r_inflight <= mem_ren;
         if (w_accept) begin
            r_addr       <= fetch_L2cache_info[MEM_AW-1:0];
            r_issue_left <= w_burst_len;
            r_ret_left   <= w_burst_len;
         end else begin
            if (mem_ren) begin
               r_last_addr  <= r_addr;
               r_addr       <= r_addr + c_ADDR_ONE;
               r_issue_left <= r_issue_left - 9'd1;
            end
            if (w_pop) begin
               r_ret_left <= r_ret_left - 9'd1;
            end
         end
      end
   end

   // -------------------------------------------------------- return buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fifo[0] <= 32'd0;
         r_fifo[1] <= 32'd0;
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= mem_rdata;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire
